// File: rtl/ahbl2apb_bridge_mp_pkg.sv
// Shared types and helpers for the multi-slave AHB-Lite to APB4 bridge.
package ahbl2apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Reads and oversized transfers never strobe any byte lane.
    function automatic logic [3:0] gen_strb(input logic write, input logic [2:0] size,
                                            input logic [1:0] addr);
        logic [3:0] strb;
        strb = 4'b0000;
        if (write) begin
            case (size)
                HSIZE_BYTE: strb = 4'b0001 << addr;
                HSIZE_HALF: strb = 4'b0011 << {addr[1], 1'b0};
                HSIZE_WORD: strb = 4'b1111;
                default:    strb = 4'b0000;
            endcase
        end
        return strb;
    endfunction

endpackage

// File: rtl/ahbl2apb_bridge_mp_if.sv
// AHB-Lite and APB4 bus bundles; the bridge is the AHB slave and the APB master.
// Handshake: an AHB transfer is taken only when HSEL, HREADY and HTRANS[1] are all high; an APB transfer completes in an ACCESS cycle with the selected PREADY high.
interface ahbl2apb_ahb_if #(parameter int ADDR_W = 32);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic              HREADY;
    logic [31:0]       HWDATA;
    logic              HREADYOUT;
    logic              HRESP;
    logic [31:0]       HRDATA;

    modport master (output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
                    input  HREADYOUT, HRESP, HRDATA);
    modport slave  (input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
                    output HREADYOUT, HRESP, HRDATA);
endinterface

interface ahbl2apb_apb_if #(parameter int ADDR_W = 32, parameter int NSLV = 4);
    logic [NSLV-1:0]      PSEL;
    logic                 PENABLE;
    logic [ADDR_W-1:0]    PADDR;
    logic                 PWRITE;
    logic [31:0]          PWDATA;
    logic [3:0]           PSTRB;
    logic [32*NSLV-1:0]   PRDATA;
    logic [NSLV-1:0]      PREADY;
    logic [NSLV-1:0]      PSLVERR;

    modport master (output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
                    output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/ahbl2apb_bridge_mp_mux.sv
// Selects one APB slave's read data, ready and error by the latched slave index.
module apb_slave_mux #(
    parameter int NSLV  = 4,
    parameter int IDX_W = 2
) (
    input  logic [IDX_W-1:0]    idx,
    input  logic [32*NSLV-1:0]  prdata,
    input  logic [NSLV-1:0]     pready,
    input  logic [NSLV-1:0]     pslverr,
    output logic [31:0]         rdata,
    output logic                ready,
    output logic                err
);

    always_comb begin
        rdata = '0;
        ready = 1'b0;
        err   = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (int'(idx) == i) begin
                rdata = prdata[32*i +: 32];
                ready = pready[i];
                err   = pslverr[i];
            end
        end
    end

endmodule

// File: rtl/ahbl2apb_bridge_mp.sv
// AHB-Lite slave to multi-slave APB4 master bridge with address decode,
// write strobes, optional PREADY timeout and a two-cycle AHB ERROR response.
module ahbl2apb_bridge_mp import ahbl2apb_pkg::*; #(
    parameter int ADDR_W  = 32,
    parameter int NSLV    = 4,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 0
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    ahbl2apb_ahb_if.slave    ahb,
    ahbl2apb_apb_if.master   apb,
    output state_e           dbg_state
);

    localparam int IDX_W  = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_e            state, state_nxt;
    logic [IDX_W-1:0]  addr_idx, idx_q;
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [3:0]        pstrb_q;
    logic [31:0]       hrdata_q;
    logic [TW-1:0]     to_cnt;
    logic              accept, bad_req, timeout_hit;
    logic              sel_ready, sel_err;
    logic [31:0]       sel_rdata;
    logic              hreadyout, hresp, penable;
    logic [NSLV-1:0]   psel_v;

    assign addr_idx = ahb.HADDR[SEL_LSB +: IDX_W];
    assign accept   = ((state == ST_IDLE) || (state == ST_ERR2)) && ahb.HSEL && ahb.HREADY &&
                      ((ahb.HTRANS == HTRANS_NONSEQ) || (ahb.HTRANS == HTRANS_SEQ));
    assign bad_req  = (int'(addr_idx) >= NSLV) || (ahb.HSIZE > HSIZE_WORD);

    // The count reaching TIMEOUT-1 on a stalled cycle means this is the TIMEOUT-th stalled ACCESS cycle.
    assign timeout_hit = (TIMEOUT > 0) && (to_cnt == TW'(TO_LIM));

    apb_slave_mux #(.NSLV(NSLV), .IDX_W(IDX_W)) u_mux (
        .idx     (idx_q),
        .prdata  (apb.PRDATA),
        .pready  (apb.PREADY),
        .pslverr (apb.PSLVERR),
        .rdata   (sel_rdata),
        .ready   (sel_ready),
        .err     (sel_err)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        penable   = 1'b0;
        psel_v    = '0;
        case (state)
            ST_IDLE, ST_ERR2: begin
                hresp = (state == ST_ERR2);
                if (accept) state_nxt = bad_req ? ST_ERR1 : ST_SETUP;
                else        state_nxt = ST_IDLE;
            end
            ST_SETUP: begin
                hreadyout = 1'b0;
                for (int i = 0; i < NSLV; i++) psel_v[i] = (int'(idx_q) == i);
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                hreadyout = 1'b0;
                penable   = 1'b1;
                for (int i = 0; i < NSLV; i++) psel_v[i] = (int'(idx_q) == i);
                if (sel_ready)        state_nxt = sel_err ? ST_ERR1 : ST_IDLE;
                else if (timeout_hit) state_nxt = ST_ERR1;
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_nxt = ST_ERR2;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pstrb_q  <= 4'b0000;
            idx_q    <= '0;
            hrdata_q <= '0;
            to_cnt   <= '0;
        end else begin
            if (accept) begin
                paddr_q  <= ahb.HADDR;
                pwrite_q <= ahb.HWRITE;
                idx_q    <= addr_idx;
                pstrb_q  <= gen_strb(ahb.HWRITE, ahb.HSIZE, ahb.HADDR[1:0]);
            end
            if (state == ST_SETUP) begin
                to_cnt <= '0;
            end else if ((state == ST_ACCESS) && !sel_ready) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if ((state == ST_ACCESS) && sel_ready && !pwrite_q) begin
                hrdata_q <= sel_rdata;
            end
        end
    end

    assign ahb.HREADYOUT = hreadyout;
    assign ahb.HRESP     = hresp;
    assign ahb.HRDATA    = hrdata_q;
    assign apb.PSEL      = psel_v;
    assign apb.PENABLE   = penable;
    assign apb.PADDR     = paddr_q;
    assign apb.PWRITE    = pwrite_q;
    assign apb.PWDATA    = ahb.HWDATA;
    assign apb.PSTRB     = pstrb_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_ahbl2apb_bridge_mp.sv
// Directed bench for ahbl2apb_bridge_mp: 5 slaves (index 5 unmapped), 8-cycle PREADY timeout.
module tb_ahbl2apb_bridge_mp;
    import ahbl2apb_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int NSLV    = 5;
    localparam int SEL_LSB = 12;
    localparam int TIMEOUT = 8;

    logic   HCLK = 1'b0;
    logic   HRESETn;
    state_e dbg_state;
    int     checks = 0;
    int     errors = 0;

    ahbl2apb_ahb_if #(.ADDR_W(ADDR_W)) ahb ();
    ahbl2apb_apb_if #(.ADDR_W(ADDR_W), .NSLV(NSLV)) apb ();

    ahbl2apb_bridge_mp #(
        .ADDR_W(ADDR_W), .NSLV(NSLV), .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .ahb       (ahb),
        .apb       (apb),
        .dbg_state (dbg_state)
    );

    always #5 HCLK = ~HCLK;

    // Single AHB slave on the bus, so the bus ready follows this slave's ready.
    assign ahb.HREADY = ahb.HREADYOUT;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz,
                              input logic [1:0] tr);
        ahb.HSEL   = 1'b1;
        ahb.HADDR  = a;
        ahb.HWRITE = w;
        ahb.HSIZE  = sz;
        ahb.HTRANS = tr;
    endtask

    task automatic bus_idle();
        ahb.HSEL   = 1'b0;
        ahb.HTRANS = HTRANS_IDLE;
    endtask

    initial begin
        HRESETn     = 1'b1;
        ahb.HSEL    = 1'b0;
        ahb.HADDR   = '0;
        ahb.HTRANS  = HTRANS_IDLE;
        ahb.HWRITE  = 1'b0;
        ahb.HSIZE   = HSIZE_WORD;
        ahb.HWDATA  = '0;
        apb.PRDATA  = '0;
        apb.PREADY  = '1;
        apb.PSLVERR = '0;
        #2 HRESETn = 1'b0;
        #20;
        chk("rst_hreadyout", 32'(ahb.HREADYOUT), 32'h1);
        chk("rst_hresp",     32'(ahb.HRESP),     32'h0);
        chk("rst_hrdata",    ahb.HRDATA,         32'h0);
        chk("rst_psel",      32'(apb.PSEL),      32'h0);
        chk("rst_penable",   32'(apb.PENABLE),   32'h0);
        chk("rst_paddr",     apb.PADDR,          32'h0);
        chk("rst_pwrite",    32'(apb.PWRITE),    32'h0);
        chk("rst_pstrb",     32'(apb.PSTRB),     32'h0);
        @(posedge HCLK);
        #3 HRESETn = 1'b1;
        step();

        // BUSY transfer is ignored with a zero-wait OKAY
        addr_phase(32'h0000_1000, 1'b1, HSIZE_WORD, HTRANS_BUSY);
        step();
        bus_idle();
        chk("busy_state",     32'(dbg_state),     32'(ST_IDLE));
        chk("busy_hreadyout", 32'(ahb.HREADYOUT), 32'h1);
        chk("busy_psel",      32'(apb.PSEL),      32'h0);

        // Single word write to slave 2
        addr_phase(32'h0000_2004, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        bus_idle();
        ahb.HWDATA = 32'hDEAD_BEEF;
        chk("wr_setup_state", 32'(dbg_state),     32'(ST_SETUP));
        chk("wr_setup_hrdy",  32'(ahb.HREADYOUT), 32'h0);
        chk("wr_setup_psel",  32'(apb.PSEL),      32'h04);
        chk("wr_setup_pen",   32'(apb.PENABLE),   32'h0);
        chk("wr_paddr",       apb.PADDR,          32'h0000_2004);
        chk("wr_pwrite",      32'(apb.PWRITE),    32'h1);
        chk("wr_pstrb",       32'(apb.PSTRB),     32'hF);
        chk("wr_pwdata",      apb.PWDATA,         32'hDEAD_BEEF);
        step();
        chk("wr_acc_hrdy",    32'(ahb.HREADYOUT), 32'h0);
        chk("wr_acc_pen",     32'(apb.PENABLE),   32'h1);
        chk("wr_acc_psel",    32'(apb.PSEL),      32'h04);
        chk("wr_acc_hresp",   32'(ahb.HRESP),     32'h0);
        step();
        chk("wr_done_hrdy",   32'(ahb.HREADYOUT), 32'h1);
        chk("wr_done_hresp",  32'(ahb.HRESP),     32'h0);
        chk("wr_done_psel",   32'(apb.PSEL),      32'h0);

        // Byte read from slave 1 with 3 PREADY-low ACCESS cycles
        apb.PREADY[1] = 1'b0;
        addr_phase(32'h0000_1003, 1'b0, HSIZE_BYTE, HTRANS_NONSEQ);
        step();
        bus_idle();
        chk("rd_w1_hrdy",  32'(ahb.HREADYOUT), 32'h0);
        chk("rd_pstrb",    32'(apb.PSTRB),     32'h0);
        chk("rd_psel",     32'(apb.PSEL),      32'h02);
        step();
        chk("rd_w2_hrdy",  32'(ahb.HREADYOUT), 32'h0);
        chk("rd_w2_pen",   32'(apb.PENABLE),   32'h1);
        step();
        chk("rd_w3_hrdy",  32'(ahb.HREADYOUT), 32'h0);
        step();
        chk("rd_w4_hrdy",  32'(ahb.HREADYOUT), 32'h0);
        step();
        chk("rd_w5_hrdy",  32'(ahb.HREADYOUT), 32'h0);
        apb.PREADY[1] = 1'b1;
        apb.PRDATA[32*1 +: 32] = 32'h1122_3344;
        step();
        chk("rd_done_hrdy", 32'(ahb.HREADYOUT), 32'h1);
        chk("rd_hrdata",    ahb.HRDATA,         32'h1122_3344);
        apb.PRDATA[32*1 +: 32] = 32'h0;

        // Halfword write to slave 0, then back-to-back word write to slave 2
        addr_phase(32'h0000_0002, 1'b1, HSIZE_HALF, HTRANS_NONSEQ);
        step();
        ahb.HWDATA = 32'hAAAA_0000;
        chk("hw_pstrb", 32'(apb.PSTRB), 32'hC);
        chk("hw_psel",  32'(apb.PSEL),  32'h01);
        addr_phase(32'h0000_2008, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        chk("hw_acc_state", 32'(dbg_state), 32'(ST_ACCESS));
        step();
        chk("hw_done_hrdy", 32'(ahb.HREADYOUT), 32'h1);
        step();
        bus_idle();
        ahb.HWDATA = 32'h1234_5678;
        chk("b2b_state",  32'(dbg_state),  32'(ST_SETUP));
        chk("b2b_psel",   32'(apb.PSEL),   32'h04);
        chk("b2b_paddr",  apb.PADDR,       32'h0000_2008);
        chk("b2b_pstrb",  32'(apb.PSTRB),  32'hF);
        step();
        step();
        chk("b2b_done_hrdy", 32'(ahb.HREADYOUT), 32'h1);
        chk("hrdata_hold",   ahb.HRDATA,         32'h1122_3344);

        // Slave error on slave 3, then a read accepted in ERR2
        addr_phase(32'h0000_3000, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        bus_idle();
        step();
        apb.PSLVERR[3] = 1'b1;
        step();
        chk("se_err1_hrdy",  32'(ahb.HREADYOUT), 32'h0);
        chk("se_err1_hresp", 32'(ahb.HRESP),     32'h1);
        chk("se_err1_psel",  32'(apb.PSEL),      32'h0);
        apb.PSLVERR[3] = 1'b0;
        addr_phase(32'h0000_4000, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        chk("se_err2_hrdy",  32'(ahb.HREADYOUT), 32'h1);
        chk("se_err2_hresp", 32'(ahb.HRESP),     32'h1);
        step();
        bus_idle();
        chk("se_next_state", 32'(dbg_state),   32'(ST_SETUP));
        chk("se_next_psel",  32'(apb.PSEL),    32'h10);
        chk("se_next_pwr",   32'(apb.PWRITE),  32'h0);
        apb.PRDATA[32*4 +: 32] = 32'hCAFE_F00D;
        step();
        step();
        chk("se_next_hrdata", ahb.HRDATA,        32'hCAFE_F00D);
        chk("se_next_hresp",  32'(ahb.HRESP),    32'h0);

        // Unmapped index 5
        addr_phase(32'h0000_5000, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        bus_idle();
        chk("um_err1_hrdy",  32'(ahb.HREADYOUT), 32'h0);
        chk("um_err1_hresp", 32'(ahb.HRESP),     32'h1);
        chk("um_err1_psel",  32'(apb.PSEL),      32'h0);
        step();
        chk("um_err2_hrdy",  32'(ahb.HREADYOUT), 32'h1);
        chk("um_err2_hresp", 32'(ahb.HRESP),     32'h1);
        chk("um_err2_psel",  32'(apb.PSEL),      32'h0);
        step();
        chk("um_after_hresp", 32'(ahb.HRESP),    32'h0);

        // Unsupported size on a mapped slave
        addr_phase(32'h0000_1000, 1'b0, 3'd3, HTRANS_NONSEQ);
        step();
        bus_idle();
        chk("sz_err1_hrdy",  32'(ahb.HREADYOUT), 32'h0);
        chk("sz_err1_hresp", 32'(ahb.HRESP),     32'h1);
        chk("sz_err1_psel",  32'(apb.PSEL),      32'h0);
        step();
        chk("sz_err2_hrdy",  32'(ahb.HREADYOUT), 32'h1);
        chk("sz_err2_hresp", 32'(ahb.HRESP),     32'h1);
        step();

        // PREADY stuck low on slave 2: abort after 8 ACCESS cycles
        apb.PREADY[2] = 1'b0;
        addr_phase(32'h0000_2000, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        bus_idle();
        for (int i = 0; i < TIMEOUT; i++) begin
            step();
            chk($sformatf("to_acc%0d_pen", i),  32'(apb.PENABLE),   32'h1);
            chk($sformatf("to_acc%0d_hrdy", i), 32'(ahb.HREADYOUT), 32'h0);
        end
        step();
        chk("to_err1_state", 32'(dbg_state),     32'(ST_ERR1));
        chk("to_err1_psel",  32'(apb.PSEL),      32'h0);
        chk("to_err1_pen",   32'(apb.PENABLE),   32'h0);
        chk("to_err1_hresp", 32'(ahb.HRESP),     32'h1);
        step();
        chk("to_err2_hrdy",  32'(ahb.HREADYOUT), 32'h1);
        chk("to_err2_hresp", 32'(ahb.HRESP),     32'h1);
        step();

        // Asynchronous reset in the middle of an ACCESS phase
        addr_phase(32'h0000_2000, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        bus_idle();
        step();
        chk("ar_pre_state", 32'(dbg_state), 32'(ST_ACCESS));
        #2 HRESETn = 1'b0;
        #1;
        chk("ar_state",     32'(dbg_state),     32'(ST_IDLE));
        chk("ar_hreadyout", 32'(ahb.HREADYOUT), 32'h1);
        chk("ar_hresp",     32'(ahb.HRESP),     32'h0);
        chk("ar_hrdata",    ahb.HRDATA,         32'h0);
        chk("ar_psel",      32'(apb.PSEL),      32'h0);
        chk("ar_penable",   32'(apb.PENABLE),   32'h0);
        chk("ar_paddr",     apb.PADDR,          32'h0);
        chk("ar_pwrite",    32'(apb.PWRITE),    32'h0);
        chk("ar_pstrb",     32'(apb.PSTRB),     32'h0);
        #3 HRESETn = 1'b1;
        apb.PREADY = '1;
        step();
        chk("ar_after_state", 32'(dbg_state), 32'(ST_IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
